// File: rtl/ddr4_dfi_cmd_issuer.sv
// ddr4_dfi_cmd_issuer: gates scheduler commands on bank/global timing and drives them on DFI phase 0
// with programmable-latency read/write data enables.
module ddr4_dfi_cmd_issuer #(
   parameter int NUM_PHASES = 4,
   parameter int A_WIDTH    = 17,
   parameter int BA_WIDTH   = 2,
   parameter int BG_WIDTH   = 2,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                           dfi_clk,
   input  logic                           reset_n,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [2:0]                     cmd_op,
   input  logic [BG_WIDTH-1:0]            cmd_bg,
   input  logic [BA_WIDTH-1:0]            cmd_ba,
   input  logic [A_WIDTH-1:0]             cmd_addr,
   input  logic [CNT_WIDTH-1:0]           t_rcd,
   input  logic [CNT_WIDTH-1:0]           t_ras,
   input  logic [CNT_WIDTH-1:0]           t_rp,
   input  logic [CNT_WIDTH-1:0]           t_ccd,
   input  logic [CNT_WIDTH-1:0]           t_rfc,
   input  logic [4:0]                     t_phy_wrlat,
   input  logic [4:0]                     t_rddata_en,
   output logic [NUM_PHASES*A_WIDTH-1:0]  dfi_address,
   output logic [NUM_PHASES*BG_WIDTH-1:0] dfi_bg,
   output logic [NUM_PHASES*BA_WIDTH-1:0] dfi_bank,
   output logic [NUM_PHASES-1:0]          dfi_cs_n,
   output logic [NUM_PHASES-1:0]          dfi_act_n,
   output logic [NUM_PHASES-1:0]          dfi_ras_n,
   output logic [NUM_PHASES-1:0]          dfi_cas_n,
   output logic [NUM_PHASES-1:0]          dfi_we_n,
   output logic [NUM_PHASES-1:0]          dfi_wrdata_en,
   output logic [NUM_PHASES-1:0]          dfi_rddata_en,
   output logic [(1<<(BG_WIDTH+BA_WIDTH))-1:0] bank_open,
   output logic                           err_illegal
);
   localparam int BW = BG_WIDTH + BA_WIDTH;
   localparam int NUM_BANKS = 1 << BW;
   localparam int BURST_CYCLES = 4 / NUM_PHASES;
   localparam int SR_W = 32 + BURST_CYCLES;
   localparam logic [SR_W-1:0] BURST = SR_W'((1 << BURST_CYCLES) - 1);

   typedef enum logic [2:0] {OP_NOP, OP_ACT, OP_RD, OP_WR, OP_PRE, OP_PREA, OP_REF, OP_RSV} op_t;

   function automatic logic [CNT_WIDTH-1:0] ld(input logic [CNT_WIDTH-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] dec(input logic [CNT_WIDTH-1:0] c);
      return (c == '0) ? '0 : c - 1'b1;
   endfunction

   op_t op;
   logic [BW-1:0] bidx;
   logic [CNT_WIDTH-1:0] rcd_q [NUM_BANKS];
   logic [CNT_WIDTH-1:0] ras_q [NUM_BANKS];
   logic [CNT_WIDTH-1:0] rp_q [NUM_BANKS];
   logic [CNT_WIDTH-1:0] ccd_q, rfc_q;
   logic [SR_W-1:0] wr_sr, rd_sr;
   logic live_q, rfc_ok, prea_ok, gate, illegal, issue, rdwr;
   logic [NUM_PHASES-1:0] cs_d, act_d, ras_d, cas_d, we_d;
   logic [NUM_PHASES*A_WIDTH-1:0] addr_d;
   logic [NUM_PHASES*BG_WIDTH-1:0] bg_d;
   logic [NUM_PHASES*BA_WIDTH-1:0] ba_d;

   assign op = op_t'(cmd_op);
   assign bidx = {cmd_bg, cmd_ba};
   assign rdwr = op == OP_RD || op == OP_WR;
   assign dfi_wrdata_en = {NUM_PHASES{wr_sr[0]}};
   assign dfi_rddata_en = {NUM_PHASES{rd_sr[0]}};

   // live_q holds cmd_ready low for the first cycle after reset
   always_comb begin
      prea_ok = 1'b1;
      for (int b = 0; b < NUM_BANKS; b++)
         if (bank_open[b] && ras_q[b] != '0) prea_ok = 1'b0;
      rfc_ok = rfc_q == '0;
      illegal = (op == OP_ACT && bank_open[bidx]) || ((rdwr || op == OP_PRE) && !bank_open[bidx])
              || (op == OP_REF && |bank_open) || op == OP_RSV;
      gate = op == OP_ACT  ? rp_q[bidx] == '0 && rfc_ok :
             rdwr          ? rcd_q[bidx] == '0 && ccd_q == '0 && rfc_ok :
             op == OP_PRE  ? ras_q[bidx] == '0 && rfc_ok :
             op == OP_PREA ? prea_ok && rfc_ok :
             op == OP_REF  ? rfc_ok : 1'b1;
      cmd_ready = live_q && (illegal || gate);
      issue = cmd_valid && cmd_ready && !illegal && op != OP_NOP;
   end

   always_comb begin
      cs_d = '1;
      act_d = '1;
      ras_d = '1;
      cas_d = '1;
      we_d = '1;
      addr_d = '0;
      bg_d = '0;
      ba_d = '0;
      if (issue) begin
         cs_d[0] = 1'b0;
         act_d[0] = op != OP_ACT;
         {ras_d[0], cas_d[0], we_d[0]} = op == OP_ACT ? cmd_addr[16:14] :
                                         op == OP_RD  ? 3'b101 :
                                         op == OP_WR  ? 3'b100 :
                                         op == OP_REF ? 3'b001 : 3'b010;
         addr_d[A_WIDTH-1:0] = cmd_addr;
         if (op == OP_PRE || op == OP_PREA) addr_d[10] = op == OP_PREA;
         bg_d[BG_WIDTH-1:0] = cmd_bg;
         ba_d[BA_WIDTH-1:0] = cmd_ba;
      end
   end

   always_ff @(posedge dfi_clk) begin
      if (!reset_n) begin
         live_q <= 1'b0;
         err_illegal <= 1'b0;
         ccd_q <= '0;
         rfc_q <= '0;
         wr_sr <= '0;
         rd_sr <= '0;
         bank_open <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            rcd_q[b] <= '0;
            ras_q[b] <= '0;
            rp_q[b] <= '0;
         end
         dfi_cs_n <= '1;
         dfi_act_n <= '1;
         dfi_ras_n <= '1;
         dfi_cas_n <= '1;
         dfi_we_n <= '1;
         dfi_address <= '0;
         dfi_bg <= '0;
         dfi_bank <= '0;
      end else begin
         live_q <= 1'b1;
         err_illegal <= cmd_valid && cmd_ready && illegal;
         ccd_q <= issue && rdwr ? ld(t_ccd) : dec(ccd_q);
         rfc_q <= issue && op == OP_REF ? ld(t_rfc) : dec(rfc_q);
         for (int b = 0; b < NUM_BANKS; b++) begin
            rcd_q[b] <= issue && op == OP_ACT && bidx == BW'(b) ? ld(t_rcd) : dec(rcd_q[b]);
            ras_q[b] <= issue && op == OP_ACT && bidx == BW'(b) ? ld(t_ras) : dec(ras_q[b]);
            rp_q[b] <= issue && ((op == OP_PRE && bidx == BW'(b)) || (op == OP_PREA && bank_open[b]))
                       ? ld(t_rp) : dec(rp_q[b]);
            if (issue && op == OP_ACT && bidx == BW'(b)) bank_open[b] <= 1'b1;
            else if (issue && ((op == OP_PRE && bidx == BW'(b)) || op == OP_PREA)) bank_open[b] <= 1'b0;
         end
         // bit 0 of each shift register is the enable for the current bus cycle
         wr_sr <= (wr_sr >> 1) | (issue && op == OP_WR ? BURST << t_phy_wrlat : '0);
         rd_sr <= (rd_sr >> 1) | (issue && op == OP_RD ? BURST << t_rddata_en : '0);
         dfi_cs_n <= cs_d;
         dfi_act_n <= act_d;
         dfi_ras_n <= ras_d;
         dfi_cas_n <= cas_d;
         dfi_we_n <= we_d;
         dfi_address <= addr_d;
         dfi_bg <= bg_d;
         dfi_bank <= ba_d;
      end
   end
endmodule

// File: tb/tb_ddr4_dfi_cmd_issuer.sv
// tb_ddr4_dfi_cmd_issuer: directed checks of gating, illegal drops, data enables and reset
// on a 1:4 and a 1:2 instance driven with identical stimulus.
module tb_ddr4_dfi_cmd_issuer;
   localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, PREA = 3'd5, REF = 3'd6;

   logic dfi_clk = 1'b0;
   logic reset_n, cmd_valid;
   logic [2:0] cmd_op;
   logic [1:0] cmd_bg, cmd_ba;
   logic [16:0] cmd_addr;
   logic [7:0] t_rcd, t_ras, t_rp, t_ccd, t_rfc;
   logic [4:0] t_phy_wrlat, t_rddata_en;

   logic a_ready, a_err, b_ready, b_err;
   logic [67:0] a_address;
   logic [33:0] b_address;
   logic [7:0] a_bg, a_bank;
   logic [3:0] b_bg, b_bank;
   logic [3:0] a_cs_n, a_act_n, a_ras_n, a_cas_n, a_we_n, a_wr, a_rd;
   logic [1:0] b_cs_n, b_act_n, b_ras_n, b_cas_n, b_we_n, b_wr, b_rd;
   logic [15:0] a_open, b_open;

   int checks = 0, failures = 0, cyc = 0;
   int n, t_act, t_pre, t_ref;
   logic [7:0] pat;
   logic [9:0] pa, pb;

   always #5 dfi_clk = ~dfi_clk;
   always @(posedge dfi_clk) cyc <= cyc + 1;

   ddr4_dfi_cmd_issuer #(.NUM_PHASES(4)) u_dut4 (
      .dfi_clk(dfi_clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
      .cmd_op(cmd_op), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
      .t_rcd(t_rcd), .t_ras(t_ras), .t_rp(t_rp), .t_ccd(t_ccd), .t_rfc(t_rfc),
      .t_phy_wrlat(t_phy_wrlat), .t_rddata_en(t_rddata_en),
      .dfi_address(a_address), .dfi_bg(a_bg), .dfi_bank(a_bank), .dfi_cs_n(a_cs_n),
      .dfi_act_n(a_act_n), .dfi_ras_n(a_ras_n), .dfi_cas_n(a_cas_n), .dfi_we_n(a_we_n),
      .dfi_wrdata_en(a_wr), .dfi_rddata_en(a_rd), .bank_open(a_open), .err_illegal(a_err));

   ddr4_dfi_cmd_issuer #(.NUM_PHASES(2)) u_dut2 (
      .dfi_clk(dfi_clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
      .cmd_op(cmd_op), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
      .t_rcd(t_rcd), .t_ras(t_ras), .t_rp(t_rp), .t_ccd(t_ccd), .t_rfc(t_rfc),
      .t_phy_wrlat(t_phy_wrlat), .t_rddata_en(t_rddata_en),
      .dfi_address(b_address), .dfi_bg(b_bg), .dfi_bank(b_bank), .dfi_cs_n(b_cs_n),
      .dfi_act_n(b_act_n), .dfi_ras_n(b_ras_n), .dfi_cas_n(b_cas_n), .dfi_we_n(b_we_n),
      .dfi_wrdata_en(b_wr), .dfi_rddata_en(b_rd), .bank_open(b_open), .err_illegal(b_err));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic offer(input logic [2:0] op, input logic [1:0] bg, input logic [1:0] ba, input logic [16:0] addr);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_bg = bg;
      cmd_ba = ba;
      cmd_addr = addr;
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      #1;
      while (!a_ready && cnt < 50) begin
         @(negedge dfi_clk);
         #1;
         cnt++;
      end
      if (cnt >= 50) check("ready_timeout", 64'(a_ready), 64'(1'b1));
   endtask

   initial begin
      reset_n = 1'b0;
      cmd_valid = 1'b0;
      offer(NOP, 2'd0, 2'd0, 17'd0);
      cmd_valid = 1'b0;
      t_rcd = 8'd5; t_ras = 8'd6; t_rp = 8'd4; t_ccd = 8'd1; t_rfc = 8'd20;
      t_phy_wrlat = 5'd7; t_rddata_en = 5'd3;
      repeat (2) @(negedge dfi_clk);
      check("rst_ready", 64'(a_ready), 64'(1'b0));
      check("rst_cs", 64'(a_cs_n), 64'(4'hF));
      check("rst_bits", 64'({a_act_n, a_ras_n, a_cas_n, a_we_n}), 64'(16'hFFFF));
      check("rst_addr", 64'(a_address), 64'(0));
      check("rst_open_en_err", 64'({a_open, a_wr, a_rd, a_err}), 64'(0));
      reset_n = 1'b1;
      @(negedge dfi_clk);

      // ACT bank 3 then RD bank 3 gated by tRCD
      offer(ACT, 2'd0, 2'd3, 17'h12345);
      #1 check("act_ready", 64'(a_ready), 64'(1'b1));
      @(negedge dfi_clk);
      t_act = cyc;
      check("act_cs", 64'(a_cs_n), 64'(4'hE));
      check("act_bits", 64'({a_act_n, a_ras_n, a_cas_n, a_we_n}), 64'(16'hEFEE));
      check("act_addr", 64'(a_address[16:0]), 64'(17'h12345));
      check("act_bank", 64'({a_bg[1:0], a_bank[1:0]}), 64'(4'd3));
      check("act_open", 64'(a_open), 64'(16'h0008));
      offer(RD, 2'd0, 2'd3, 17'h40);
      wait_ready(n);
      check("rcd_low_cycles", 64'(n), 64'(4));
      @(negedge dfi_clk);
      check("rd_gap", 64'(cyc - t_act), 64'(5));
      check("rd_bits", 64'({a_act_n, a_ras_n, a_cas_n, a_we_n}), 64'(16'hFFEF));
      cmd_valid = 1'b0;
      repeat (10) @(negedge dfi_clk);

      // four back-to-back RDs at tCCD=1, read enable latency 3
      offer(RD, 2'd0, 2'd3, 17'h80);
      pat = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge dfi_clk);
         pat = {pat[6:0], a_rd == 4'hF};
         if (i == 3) begin
            check("rd_en_full", 64'(a_rd), 64'(4'hF));
            cmd_valid = 1'b0;
         end
      end
      check("rd_stream", 64'(pat), 64'(8'b0001_1110));

      // WR with write latency 7 on both ratios
      offer(WR, 2'd0, 2'd3, 17'h100);
      #1 check("wr_ready", 64'(a_ready), 64'(1'b1));
      pa = '0;
      pb = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge dfi_clk);
         if (i == 0) begin
            check("wr_bits", 64'({a_ras_n, a_cas_n, a_we_n}), 64'(12'hFEE));
            cmd_valid = 1'b0;
         end
         if (i == 7) check("wr_en4", 64'(a_wr), 64'(4'hF));
         pa = {pa[8:0], a_wr == 4'hF};
         pb = {pb[8:0], b_wr == 2'b11};
      end
      check("wr_pat4", 64'(pa), 64'(10'b0000000100));
      check("wr_pat2", 64'(pb), 64'(10'b0000000110));

      // illegal: RD to closed bank 9
      offer(RD, 2'd2, 2'd1, 17'h0);
      #1 check("ill_rd_ready", 64'(a_ready), 64'(1'b1));
      @(negedge dfi_clk);
      cmd_valid = 1'b0;
      check("ill_rd_cs", 64'(a_cs_n), 64'(4'hF));
      check("ill_rd_err", 64'(a_err), 64'(1'b1));
      @(negedge dfi_clk);
      check("ill_rd_err_pulse", 64'(a_err), 64'(1'b0));
      check("ill_rd_open", 64'(a_open), 64'(16'h0008));

      // open bank 0, then REF with banks open is dropped
      offer(ACT, 2'd0, 2'd0, 17'h10);
      wait_ready(n);
      @(negedge dfi_clk);
      check("act0_open", 64'(a_open), 64'(16'h0009));
      offer(REF, 2'd0, 2'd0, 17'h0);
      #1 check("ill_ref_ready", 64'(a_ready), 64'(1'b1));
      @(negedge dfi_clk);
      check("ill_ref_cs", 64'(a_cs_n), 64'(4'hF));
      check("ill_ref_err", 64'(a_err), 64'(1'b1));
      check("ill_ref_open", 64'(a_open), 64'(16'h0009));

      // PREA waits on bank 0 tRAS, then REF, then ACT gated by tRFC
      offer(PREA, 2'd0, 2'd0, 17'h0);
      wait_ready(n);
      check("prea_ras_wait", 64'(n), 64'(4));
      @(negedge dfi_clk);
      t_pre = cyc;
      cmd_valid = 1'b0;
      check("prea_bits", 64'({a_act_n, a_ras_n, a_cas_n, a_we_n}), 64'(16'hFEFE));
      check("prea_a10", 64'(a_address[10]), 64'(1'b1));
      check("prea_open", 64'(a_open), 64'(16'h0000));
      repeat (3) @(negedge dfi_clk);
      offer(REF, 2'd0, 2'd0, 17'h0);
      #1 check("ref_ready", 64'(a_ready), 64'(1'b1));
      @(negedge dfi_clk);
      t_ref = cyc;
      check("ref_gap", 64'(t_ref - t_pre), 64'(4));
      check("ref_bits", 64'({a_act_n, a_ras_n, a_cas_n, a_we_n}), 64'(16'hFEEF));
      offer(ACT, 2'd1, 2'd1, 17'h20);
      wait_ready(n);
      check("rfc_low_cycles", 64'(n), 64'(19));
      @(negedge dfi_clk);
      check("act_after_ref_gap", 64'(cyc - t_ref), 64'(20));
      check("act5_open", 64'(a_open), 64'(16'h0020));

      // reset in the middle of a 1:2 write burst
      offer(WR, 2'd1, 2'd1, 17'h8);
      wait_ready(n);
      check("wr5_rcd_wait", 64'(n), 64'(4));
      for (int i = 0; i < 9; i++) begin
         @(negedge dfi_clk);
         if (i == 0) cmd_valid = 1'b0;
         if (i == 7) begin
            check("pre_rst_en2", 64'(b_wr), 64'(2'b11));
            reset_n = 1'b0;
         end
      end
      check("mid_rst_en", 64'({a_wr, b_wr, a_rd, b_rd}), 64'(0));
      check("mid_rst_cs", 64'({a_cs_n, b_cs_n}), 64'(6'h3F));
      check("mid_rst_open", 64'({a_open, b_open}), 64'(0));
      check("mid_rst_ready", 64'(a_ready), 64'(1'b0));
      reset_n = 1'b1;
      @(negedge dfi_clk);
      check("post_rst_en", 64'({a_wr, b_wr}), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
